// File: rtl/axis_pkt_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkt_pkg
// Shared types and helpers for the AXI-Stream packet sink.
//   state_t          : packet framing state (IDLE / IN_PKT)
//   desc_t           : per-packet descriptor (bytes, beats, ifg, error bits)
//   popcount_strb    : number of enabled bytes in a strobe word
//   strb_contiguous  : strobe is nonzero and of the form 0..01..1
//   PCAP_*           : constants for the optional pcap dump header
// Strobe helpers take a fixed MAX_STRB-wide argument; callers zero-extend.
// ---------------------------------------------------------------------------
package axis_pkt_pkg;

    localparam int MAX_STRB = 128;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] bytes;
        logic [15:0] beats;
        logic [31:0] ifg;
        logic        len_err;
        logic        strb_err;
        logic        oversize;
    } desc_t;

    localparam logic [31:0] PCAP_MAGIC_NS  = 32'hA1B2_3C4D;
    localparam logic [15:0] PCAP_VER_MAJOR = 16'd2;
    localparam logic [15:0] PCAP_VER_MINOR = 16'd4;
    localparam logic [31:0] PCAP_SNAPLEN   = 32'd65535;
    localparam logic [31:0] PCAP_LINKTYPE  = 32'd1;

    function automatic logic [7:0] popcount_strb(input logic [MAX_STRB-1:0] strb);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < MAX_STRB; i++) begin
            cnt = cnt + {7'd0, strb[i]};
        end
        return cnt;
    endfunction

    // Ones-then-zeros: adding one to a run of low ones carries out of the run
    // and leaves no bit in common with the original value.
    function automatic logic strb_contiguous(input logic [MAX_STRB-1:0] strb);
        return (strb != '0) && ((strb & (strb + MAX_STRB'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// ---------------------------------------------------------------------------
// axis_ready_gen
// Registered ready generator for the packet sink.
//   clk, rst     : clock, asynchronous active-high reset
//   force_stall  : holds ready low while high (one-cycle registered lag)
//   s_ready      : registered ready = pattern && !force_stall
// READY_MODE=0 gives a constant-high pattern. READY_MODE=1 runs a phase
// counter 0..READY_PERIOD-1; the pattern is low for the last READY_OFF phases.
// ---------------------------------------------------------------------------
module axis_ready_gen #(
    parameter int READY_MODE   = 0,
    parameter int READY_PERIOD = 4,
    parameter int READY_OFF    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic force_stall,
    output logic s_ready
);

    localparam int PW = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          ready_q, ready_d;
    logic          pattern;

    always_comb begin
        phase_d = (phase_q == PW'(READY_PERIOD - 1)) ? '0 : phase_q + PW'(1);
        if (READY_MODE == 0) begin
            pattern = 1'b1;
        end else begin
            pattern = (phase_q < PW'(READY_PERIOD - READY_OFF));
        end
        ready_d = pattern && !force_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            ready_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ready_q <= ready_d;
        end
    end

    assign s_ready = ready_q;

endmodule

// File: rtl/axis_pkt_sink.sv
// ---------------------------------------------------------------------------
// axis_pkt_sink
// Receive end of the packet-replay AXI-Stream link. Accepts beats when
// s_valid && s_ready (both sampled on the same rising edge; nothing is
// sampled otherwise), checks strobe framing and length, measures packet size
// and inter-frame gap, and emits a registered one-cycle descriptor per
// completed packet together with running counters.
//   clk, rst            : clock, asynchronous active-high reset
//   s_data/s_strb/s_len : beat payload, byte enables (LSB first), pkt length
//   s_valid/s_eop       : beat valid, last beat of packet
//   s_ready             : registered sink ready (see axis_ready_gen)
//   force_stall         : forces s_ready low
//   desc_*              : descriptor, valid for the single desc_valid cycle
//   pkt_count/byte_count/err_count : running totals, updated with desc_valid
//   state               : current framing state, exposed for checkers
// ---------------------------------------------------------------------------
module axis_pkt_sink
    import axis_pkt_pkg::*;
#(
    parameter int    AXIS_WIDTH    = 512,
    parameter int    READY_MODE    = 0,
    parameter int    READY_PERIOD  = 4,
    parameter int    READY_OFF     = 1,
    parameter int    CHECK_LEN     = 1,
    parameter int    MAX_BEATS     = 190,
    parameter string DUMP_FILENAME = "sink_out.pcap",
    parameter int    CLOCK_FREQ_HZ = 322265625
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXIS_WIDTH-1:0]   s_data,
    input  logic [AXIS_WIDTH/8-1:0] s_strb,
    input  logic [47:0]             s_len,
    input  logic                    s_valid,
    input  logic                    s_eop,
    output logic                    s_ready,
    input  logic                    force_stall,
    output logic                    desc_valid,
    output logic [31:0]             desc_bytes,
    output logic [15:0]             desc_beats,
    output logic [31:0]             desc_ifg,
    output logic                    desc_len_err,
    output logic                    desc_strb_err,
    output logic                    desc_oversize,
    output logic [31:0]             pkt_count,
    output logic [63:0]             byte_count,
    output logic [15:0]             err_count,
    output state_t                  state
);

    localparam int BPB = AXIS_WIDTH / 8;

    axis_ready_gen #(
        .READY_MODE   (READY_MODE),
        .READY_PERIOD (READY_PERIOD),
        .READY_OFF    (READY_OFF)
    ) u_ready (
        .clk         (clk),
        .rst         (rst),
        .force_stall (force_stall),
        .s_ready     (s_ready)
    );

    state_t        state_q, state_d;
    logic          first_pkt_q, first_pkt_d;
    logic [31:0]   ifg_cnt_q, ifg_cnt_d;
    logic [31:0]   ifg_rec_q, ifg_rec_d;
    logic [47:0]   len_q, len_d;
    logic [15:0]   beats_q, beats_d;
    logic [31:0]   bytes_q, bytes_d;
    logic          len_err_q, len_err_d;
    logic          strb_err_q, strb_err_d;
    desc_t         desc_q, desc_d;
    logic          desc_valid_q, desc_valid_d;
    logic [31:0]   pkt_count_q, pkt_count_d;
    logic [63:0]   byte_count_q, byte_count_d;
    logic [15:0]   err_count_q, err_count_d;

    logic [MAX_STRB-1:0] strb_ext;
    logic [31:0]         pop32;
    logic                accept, is_idle;
    logic [15:0]         beats_nxt;
    logic [31:0]         bytes_nxt;
    logic [31:0]         ifg_nxt;
    logic [47:0]         len_ref;
    logic                strb_bad, strb_err_nxt, len_err_nxt;
    desc_t               desc_n;

    always_comb begin
        strb_ext = '0;
        strb_ext[BPB-1:0] = s_strb;
    end

    assign pop32   = {24'd0, popcount_strb(strb_ext)};
    assign accept  = s_valid && s_ready;
    assign is_idle = (state_q == IDLE);

    always_comb begin
        // Packet accumulators as they would stand after accepting this beat.
        beats_nxt    = is_idle ? 16'd1
                     : ((beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1);
        bytes_nxt    = (is_idle ? 32'd0 : bytes_q) + pop32;
        strb_bad     = s_eop ? !strb_contiguous(strb_ext) : !(&s_strb);
        strb_err_nxt = (!is_idle && strb_err_q) || strb_bad;
        len_ref      = is_idle ? s_len : len_q;
        len_err_nxt  = !is_idle && (len_err_q || (s_len != len_q));
        ifg_nxt      = is_idle ? (first_pkt_q ? 32'd0 : ifg_cnt_q) : ifg_rec_q;

        desc_n.bytes    = bytes_nxt;
        desc_n.beats    = beats_nxt;
        desc_n.ifg      = ifg_nxt;
        desc_n.len_err  = (CHECK_LEN != 0) &&
                          (len_err_nxt || ({16'd0, bytes_nxt} != len_ref));
        desc_n.strb_err = strb_err_nxt;
        desc_n.oversize = ({16'd0, beats_nxt} > 32'(MAX_BEATS));

        state_d      = state_q;
        first_pkt_d  = first_pkt_q;
        ifg_cnt_d    = ifg_cnt_q;
        ifg_rec_d    = ifg_rec_q;
        len_d        = len_q;
        beats_d      = beats_q;
        bytes_d      = bytes_q;
        len_err_d    = len_err_q;
        strb_err_d   = strb_err_q;
        desc_d       = desc_q;
        desc_valid_d = 1'b0;
        pkt_count_d  = pkt_count_q;
        byte_count_d = byte_count_q;
        err_count_d  = err_count_q;

        if (is_idle && (ifg_cnt_q != 32'hFFFF_FFFF)) begin
            ifg_cnt_d = ifg_cnt_q + 32'd1;
        end

        if (accept) begin
            beats_d    = beats_nxt;
            bytes_d    = bytes_nxt;
            strb_err_d = strb_err_nxt;
            len_err_d  = len_err_nxt;
            len_d      = len_ref;
            ifg_rec_d  = ifg_nxt;
            if (s_eop) begin
                // Completion: descriptor and totals land on the same edge.
                state_d      = IDLE;
                ifg_cnt_d    = 32'd0;
                first_pkt_d  = 1'b0;
                desc_d       = desc_n;
                desc_valid_d = 1'b1;
                pkt_count_d  = pkt_count_q + 32'd1;
                byte_count_d = byte_count_q + {32'd0, bytes_nxt};
                if ((desc_n.len_err || desc_n.strb_err || desc_n.oversize) &&
                    (err_count_q != 16'hFFFF)) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end else begin
                state_d = IN_PKT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            first_pkt_q  <= 1'b1;
            ifg_cnt_q    <= '0;
            ifg_rec_q    <= '0;
            len_q        <= '0;
            beats_q      <= '0;
            bytes_q      <= '0;
            len_err_q    <= 1'b0;
            strb_err_q   <= 1'b0;
            desc_q       <= '0;
            desc_valid_q <= 1'b0;
            pkt_count_q  <= '0;
            byte_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            first_pkt_q  <= first_pkt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            ifg_rec_q    <= ifg_rec_d;
            len_q        <= len_d;
            beats_q      <= beats_d;
            bytes_q      <= bytes_d;
            len_err_q    <= len_err_d;
            strb_err_q   <= strb_err_d;
            desc_q       <= desc_d;
            desc_valid_q <= desc_valid_d;
            pkt_count_q  <= pkt_count_d;
            byte_count_q <= byte_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign desc_valid    = desc_valid_q;
    assign desc_bytes    = desc_q.bytes;
    assign desc_beats    = desc_q.beats;
    assign desc_ifg      = desc_q.ifg;
    assign desc_len_err  = desc_q.len_err;
    assign desc_strb_err = desc_q.strb_err;
    assign desc_oversize = desc_q.oversize;
    assign pkt_count     = pkt_count_q;
    assign byte_count    = byte_count_q;
    assign err_count     = err_count_q;
    assign state         = state_q;

    logic unused_cfg;
    assign unused_cfg = ^{s_data, (DUMP_FILENAME != ""), (CLOCK_FREQ_HZ != 0),
                          PCAP_MAGIC_NS, PCAP_VER_MAJOR, PCAP_VER_MINOR,
                          PCAP_SNAPLEN, PCAP_LINKTYPE};

endmodule

// File: tb/tb_axis_pkt_sink.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_sink
// Directed bench for axis_pkt_sink. dut_a: constant ready, length checking.
// dut_b: periodic ready (period 4, one off), no length check, MAX_BEATS=8.
// Both share data/strb/len/eop and reset; each has its own s_valid.
// ---------------------------------------------------------------------------
module tb_axis_pkt_sink;
  import axis_pkt_pkg::*;

  localparam logic [63:0] ALL   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] S60   = 64'h0FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] S36   = 64'h0000_000F_FFFF_FFFF;
  localparam logic [63:0] ALLB0 = 64'hFFFF_FFFF_FFFF_FFFE;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [511:0] s_data;
  logic [63:0]  s_strb;
  logic [47:0]  s_len;
  logic         s_eop, s_valid_a, s_valid_b, force_stall;

  logic s_ready_a, dv_a, le_a, se_a, ov_a;
  logic [31:0] by_a, ifg_a, pc_a;
  logic [15:0] bt_a, ec_a;
  logic [63:0] bc_a;
  state_t st_a;

  logic s_ready_b, dv_b, le_b, se_b, ov_b;
  logic [31:0] by_b, ifg_b, pc_b;
  logic [15:0] bt_b, ec_b;
  logic [63:0] bc_b;
  state_t st_b;

  axis_pkt_sink #(.AXIS_WIDTH(512), .READY_MODE(0), .CHECK_LEN(1), .MAX_BEATS(190)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_strb(s_strb), .s_len(s_len),
    .s_valid(s_valid_a), .s_eop(s_eop), .s_ready(s_ready_a), .force_stall(force_stall),
    .desc_valid(dv_a), .desc_bytes(by_a), .desc_beats(bt_a), .desc_ifg(ifg_a),
    .desc_len_err(le_a), .desc_strb_err(se_a), .desc_oversize(ov_a),
    .pkt_count(pc_a), .byte_count(bc_a), .err_count(ec_a), .state(st_a)
  );

  axis_pkt_sink #(.AXIS_WIDTH(512), .READY_MODE(1), .READY_PERIOD(4), .READY_OFF(1),
                  .CHECK_LEN(0), .MAX_BEATS(8)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_strb(s_strb), .s_len(s_len),
    .s_valid(s_valid_b), .s_eop(s_eop), .s_ready(s_ready_b), .force_stall(1'b0),
    .desc_valid(dv_b), .desc_bytes(by_b), .desc_beats(bt_b), .desc_ifg(ifg_b),
    .desc_len_err(le_b), .desc_strb_err(se_b), .desc_oversize(ov_b),
    .pkt_count(pc_b), .byte_count(bc_b), .err_count(ec_b), .state(st_b)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // captured descriptor
  logic        g_valid, g_lerr, g_serr, g_ovs;
  logic [31:0] g_bytes, g_ifg, g_pkts;
  logic [15:0] g_beats, g_ecnt;
  logic [63:0] g_bcnt;

  // driver: one packet, each beat held until accepted (bounded)
  task automatic send_pkt(input int dut, input int nbeats, input logic [63:0] strb_mid,
                          input logic [63:0] strb_last, input logic [47:0] len,
                          input logic eop_last);
    logic acc, rdy;
    for (int b = 0; b < nbeats; b++) begin
      acc = 1'b0;
      @(negedge clk);
      s_data = {16{$urandom()}};
      s_strb = (b == nbeats - 1) ? strb_last : strb_mid;
      s_eop  = (b == nbeats - 1) && eop_last;
      s_len  = len;
      if (dut == 0) s_valid_a = 1'b1; else s_valid_b = 1'b1;
      for (int w = 0; w < 16 && !acc; w++) begin
        rdy = (dut == 0) ? s_ready_a : s_ready_b;
        @(posedge clk);
        acc = rdy;
        #1;
      end
      chk("beat_accept", acc, 1'b1);
      s_valid_a = 1'b0;
      s_valid_b = 1'b0;
      s_eop     = 1'b0;
    end
  endtask

  // monitor: sample the cycle after the eop accept
  task automatic grab(input int dut);
    @(negedge clk);
    if (dut == 0) begin
      g_valid = dv_a; g_bytes = by_a; g_beats = bt_a; g_ifg = ifg_a;
      g_lerr = le_a; g_serr = se_a; g_ovs = ov_a; g_pkts = pc_a; g_bcnt = bc_a; g_ecnt = ec_a;
    end else begin
      g_valid = dv_b; g_bytes = by_b; g_beats = bt_b; g_ifg = ifg_b;
      g_lerr = le_b; g_serr = se_b; g_ovs = ov_b; g_pkts = pc_b; g_bcnt = bc_b; g_ecnt = ec_b;
    end
    chk("desc_valid", g_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, adj, seen;
    logic prev_low;
    rst = 1'b1;
    s_data = '0; s_strb = '0; s_len = '0; s_eop = 1'b0;
    s_valid_a = 1'b0; s_valid_b = 1'b0; force_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", s_ready_a, 1'b0);
    chk("rst_ready_b", s_ready_b, 1'b0);
    chk("rst_desc_valid", dv_a, 1'b0);
    chk("rst_pkt_count", pc_a, 0);
    chk("rst_byte_count", bc_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", s_ready_a, 1'b1);

    // IFG: first packet reports 0, second accepted 7 cycles after eop -> 6
    send_pkt(0, 1, ALL, ALL, 64, 1'b1);
    grab(0);
    chk("ifg1_bytes", g_bytes, 64);
    chk("ifg1_ifg", g_ifg, 0);
    repeat (5) @(negedge clk);
    send_pkt(0, 1, ALL, ALL, 64, 1'b1);
    grab(0);
    chk("ifg2_ifg", g_ifg, 6);
    chk("ifg2_pkts", g_pkts, 2);
    chk("ifg2_bcnt", g_bcnt, 128);
    @(negedge clk);
    chk("desc_pulse_one_cycle", dv_a, 1'b0);

    // single beat, 60 bytes
    send_pkt(0, 1, ALL, S60, 60, 1'b1);
    grab(0);
    chk("p60_bytes", g_bytes, 60);
    chk("p60_beats", g_beats, 1);
    chk("p60_errs", {g_lerr, g_serr, g_ovs}, 3'b000);
    chk("p60_pkts", g_pkts, 3);
    chk("p60_bcnt", g_bcnt, 188);

    // 130 bytes over 3 beats
    send_pkt(0, 3, ALL, 64'h3, 130, 1'b1);
    grab(0);
    chk("p130_bytes", g_bytes, 130);
    chk("p130_beats", g_beats, 3);
    chk("p130_errs", {g_lerr, g_serr, g_ovs}, 3'b000);
    chk("p130_bcnt", g_bcnt, 318);

    // 100 bytes with len 98
    send_pkt(0, 2, ALL, S36, 98, 1'b1);
    grab(0);
    chk("len_bytes", g_bytes, 100);
    chk("len_err", g_lerr, 1'b1);
    chk("len_strb_err", g_serr, 1'b0);
    chk("len_err_count", g_ecnt, 1);

    // non-contiguous eop strobe
    send_pkt(0, 1, ALL, 64'h5, 2, 1'b1);
    grab(0);
    chk("eop_strb_err", g_serr, 1'b1);
    chk("eop_strb_len_err", g_lerr, 1'b0);
    chk("eop_strb_ecnt", g_ecnt, 2);

    // middle beat not all ones
    send_pkt(0, 2, ALLB0, 64'h1, 64, 1'b1);
    grab(0);
    chk("mid_strb_err", g_serr, 1'b1);
    chk("mid_strb_bytes", g_bytes, 64);
    chk("mid_strb_ecnt", g_ecnt, 3);
    chk("mid_strb_pkts", g_pkts, 7);
    chk("mid_strb_bcnt", g_bcnt, 484);

    // force_stall
    @(negedge clk);
    force_stall = 1'b1;
    @(negedge clk);
    chk("stall_ready", s_ready_a, 1'b0);
    force_stall = 1'b0;
    @(negedge clk);
    chk("unstall_ready", s_ready_a, 1'b1);

    // periodic ready: exactly 1 low in every 4, never two in a row
    lows = 0; adj = 0; prev_low = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!s_ready_b) begin
        lows++;
        if (prev_low) adj++;
      end
      prev_low = !s_ready_b;
    end
    chk("ready_b_low_count", lows, 4);
    chk("ready_b_adjacent_low", adj, 0);

    // CHECK_LEN=0: mismatch ignored
    send_pkt(1, 2, ALL, S36, 98, 1'b1);
    grab(1);
    chk("nolen_bytes", g_bytes, 100);
    chk("nolen_len_err", g_lerr, 1'b0);

    // continuous valid under backpressure; 8 beats = MAX_BEATS boundary
    send_pkt(1, 8, ALL, ALL, 512, 1'b1);
    grab(1);
    chk("bp8_bytes", g_bytes, 512);
    chk("bp8_beats", g_beats, 8);
    chk("bp8_oversize", g_ovs, 1'b0);
    chk("bp8_bcnt", g_bcnt, 612);
    send_pkt(1, 9, ALL, ALL, 576, 1'b1);
    grab(1);
    chk("bp9_beats", g_beats, 9);
    chk("bp9_oversize", g_ovs, 1'b1);

    // reset mid-packet on dut_a
    send_pkt(0, 2, ALL, ALL, 640, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", s_ready_a, 1'b0);
    seen = 0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dv_a) seen++;
    end
    chk("abort_no_desc", seen, 0);
    chk("abort_pkts", pc_a, 0);
    chk("abort_bcnt", bc_a, 0);
    chk("abort_ecnt", ec_a, 0);
    chk("abort_ready", s_ready_a, 1'b1);

    // first packet after reset again reports ifg 0
    send_pkt(0, 1, ALL, ALL, 64, 1'b1);
    grab(0);
    chk("post_rst_ifg", g_ifg, 0);
    chk("post_rst_pkts", g_pkts, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
